// File: rtl/evg_tx_arbiter.sv
// EVG transmit slot arbiter: sequencer, heartbeat, TOD and channel events onto a 16-bit link.
// Optional EVG_TX_ROUND_ROBIN_EN: round-robin channel grants instead of fixed priority.
module evg_tx_arbiter #(
  parameter int TXCLK_NOMINAL_FREQUENCY = 125000000,
  parameter int TOD_SECONDS_WIDTH       = 32,
  parameter int NCHAN                   = 4,
  parameter int COMMA_INTERVAL          = 4,
  parameter int TOD_BIT_SPACING         = TXCLK_NOMINAL_FREQUENCY / 1000000
) (
  input  logic                         evgTxClk,
  input  logic                         evgTxReset,
  input  logic                         sysPPStoggle,
  input  logic [TOD_SECONDS_WIDTH-1:0] sysSeconds,
  input  logic                         evgHeartbeatRequest,
  input  logic [7:0]                   evgDistributedBus,
  input  logic [7:0]                   evgSequenceEventTDATA,
  input  logic                         evgSequenceEventTVALID,
  input  logic [NCHAN*8-1:0]           evgEventTDATA,
  input  logic [NCHAN-1:0]             evgEventTVALID,
  output logic [NCHAN-1:0]             evgEventTREADY,
  output logic [15:0]                  evgTxData,
  output logic [1:0]                   evgTxCharIsK,
  output logic                         todBusy
);
  localparam longint DELAY_LOAD = longint'(TXCLK_NOMINAL_FREQUENCY) * 7 / 8 - 1;
  localparam int DELAY_W    = (DELAY_LOAD > 0) ? $clog2(DELAY_LOAD + 1) : 1;
  localparam int SPACE_LOAD = (TOD_BIT_SPACING > 1) ? TOD_BIT_SPACING - 1 : 0;
  localparam int SPACE_W    = (SPACE_LOAD > 0) ? $clog2(SPACE_LOAD + 1) : 1;
  localparam int BITS_W     = $clog2(TOD_SECONDS_WIDTH + 1);
  localparam int COMMA_W    = $clog2(COMMA_INTERVAL);
  localparam int CH_W       = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  logic [2:0]                   ppsSync;
  logic                         ppsEdge;
  logic                         hbPending;
  logic                         markerPending;
  logic                         delayActive;
  logic [DELAY_W-1:0]           delayCnt;
  logic [TOD_SECONDS_WIDTH-1:0] shiftReg;
  logic [BITS_W-1:0]            bitsLeft;
  logic                         bitPending;
  logic                         curBit;
  logic [SPACE_W-1:0]           spaceCnt;
  logic [COMMA_W-1:0]           commaCnt;
  logic [CH_W-1:0]              lastGrant;

  logic            chanAny;
  logic [CH_W-1:0] grantIdx;
  logic [7:0]      chanCode;
  logic [7:0]      code;
  logic            codeIsK;
  logic            sendHb, sendMarker, sendBit, sendComma, chanXfer;

  // stages 0-1 synchronise the toggle, stage 2 holds the previous level for edge detection
  assign ppsEdge = ppsSync[1] ^ ppsSync[2];
  assign todBusy = markerPending | delayActive | (bitsLeft != '0) | bitPending;

  always_comb begin
    chanAny  = 1'b0;
    grantIdx = '0;
    chanCode = 8'h00;
`ifdef EVG_TX_ROUND_ROBIN_EN
    for (int k = 1; k <= NCHAN; k++) begin
      for (int i = 0; i < NCHAN; i++) begin
        if (!chanAny && evgEventTVALID[i] && (i == (int'(lastGrant) + k) % NCHAN)) begin
          chanAny  = 1'b1;
          grantIdx = CH_W'(i);
          chanCode = evgEventTDATA[i*8 +: 8];
        end
      end
    end
`else
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (evgEventTVALID[i]) begin
        chanAny  = 1'b1;
        grantIdx = CH_W'(i);
        chanCode = evgEventTDATA[i*8 +: 8];
      end
    end
`endif
  end

  always_comb begin
    code           = 8'h00;
    codeIsK        = 1'b0;
    sendHb         = 1'b0;
    sendMarker     = 1'b0;
    sendBit        = 1'b0;
    sendComma      = 1'b0;
    chanXfer       = 1'b0;
    evgEventTREADY = '0;
    if (evgSequenceEventTVALID) begin
      code = evgSequenceEventTDATA;
    end else if (hbPending || evgHeartbeatRequest) begin
      code   = 8'h7A;
      sendHb = 1'b1;
    end else if (markerPending) begin
      code       = 8'h7D;
      sendMarker = 1'b1;
    end else if (chanAny) begin
      code     = chanCode;
      chanXfer = 1'b1;
      evgEventTREADY[grantIdx] = !evgTxReset;
    end else if (bitPending) begin
      code    = {7'b0111000, curBit};
      sendBit = 1'b1;
    end else if (commaCnt == '0) begin
      code      = 8'hBC;
      codeIsK   = 1'b1;
      sendComma = 1'b1;
    end
  end

  // output register: code chosen in cycle n leaves in cycle n+1
  always_ff @(posedge evgTxClk) begin
    if (evgTxReset) begin
      evgTxData    <= 16'h0000;
      evgTxCharIsK <= 2'b00;
      hbPending    <= 1'b0;
      commaCnt     <= '0;
      lastGrant    <= CH_W'(NCHAN - 1);
    end else begin
      evgTxData    <= {evgDistributedBus, code};
      evgTxCharIsK <= {1'b0, codeIsK};
      hbPending    <= sendHb ? 1'b0 : (hbPending | evgHeartbeatRequest);
      if (sendComma)
        commaCnt <= COMMA_W'(COMMA_INTERVAL - 1);
      else if (commaCnt != '0)
        commaCnt <= commaCnt - 1'b1;
      if (chanXfer)
        lastGrant <= grantIdx;
    end
  end

  // TOD sequencer: marker, 7/8 s delay, then seconds bits MSB first
  always_ff @(posedge evgTxClk) begin
    if (evgTxReset) begin
      ppsSync       <= {3{sysPPStoggle}};
      markerPending <= 1'b0;
      delayActive   <= 1'b0;
      delayCnt      <= '0;
      shiftReg      <= '0;
      bitsLeft      <= '0;
      bitPending    <= 1'b0;
      curBit        <= 1'b0;
      spaceCnt      <= '0;
    end else begin
      ppsSync <= {ppsSync[1:0], sysPPStoggle};
      if (ppsEdge) begin
        markerPending <= 1'b1;
        delayActive   <= 1'b1;
        delayCnt      <= DELAY_W'(DELAY_LOAD);
        bitsLeft      <= '0;
        bitPending    <= 1'b0;
        spaceCnt      <= '0;
      end else begin
        if (sendMarker)
          markerPending <= 1'b0;
        if (sendBit)
          bitPending <= 1'b0;
        if (spaceCnt != '0)
          spaceCnt <= spaceCnt - 1'b1;
        if (delayActive) begin
          if (delayCnt == '0) begin
            delayActive <= 1'b0;
            curBit      <= sysSeconds[TOD_SECONDS_WIDTH-1];
            shiftReg    <= sysSeconds << 1;
            bitsLeft    <= BITS_W'(TOD_SECONDS_WIDTH - 1);
            bitPending  <= 1'b1;
            spaceCnt    <= SPACE_W'(SPACE_LOAD);
          end else begin
            delayCnt <= delayCnt - 1'b1;
          end
        end else if (bitsLeft != '0 && !bitPending && spaceCnt == '0) begin
          curBit     <= shiftReg[TOD_SECONDS_WIDTH-1];
          shiftReg   <= shiftReg << 1;
          bitsLeft   <= bitsLeft - 1'b1;
          bitPending <= 1'b1;
          spaceCnt   <= SPACE_W'(SPACE_LOAD);
        end
      end
    end
  end
endmodule
